// File: rtl/dmem_arbiter.sv
// dmem_arbiter: CPU-priority arbiter for the single-port data RAM with VGA starvation guard
module dmem_arbiter #(
  parameter int          STARVE_MAX = 4,
  parameter logic [31:0] ADDR_LIMIT = 32'h0000_2000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_a,
  input  logic [31:0] cpu_wd,
  output logic        cpu_stall,
  output logic        cpu_rvalid,
  output logic [31:0] cpu_rd,
  input  logic        vga_req,
  input  logic [31:0] vga_a,
  output logic        vga_gnt,
  output logic        vga_rvalid,
  output logic [31:0] vga_rd,
  output logic        ram_we,
  output logic [31:0] ram_a,
  output logic [31:0] ram_wd,
  input  logic [31:0] ram_rd,
  output logic        oob_err
);
  typedef enum logic [1:0] {NONE, CPU, VGA} owner_t;
  localparam logic [3:0] SMAX = 4'(STARVE_MAX);
  owner_t state, state_n;
  logic [3:0] streak, streak_n;
  logic oob, cpu_win, vga_win, in_range;
  logic [31:0] addr;
  always_comb begin
    cpu_win = ~reset & cpu_req & (~vga_req | (streak < SMAX));
    vga_win = ~reset & vga_req & ~cpu_win;
    addr = cpu_win ? cpu_a : vga_win ? vga_a : 32'h0;
    in_range = addr < ADDR_LIMIT;
    state_n = (cpu_win & ~cpu_we) ? CPU : vga_win ? VGA : NONE;
    streak_n = (~vga_req | vga_win) ? 4'd0 : (cpu_win && streak < SMAX) ? streak + 4'd1 : streak;
    cpu_stall = cpu_req & ~cpu_win & ~reset;
    vga_gnt = vga_win;
    ram_a = in_range ? addr : 32'h0;
    ram_wd = cpu_wd;
    ram_we = cpu_win & cpu_we & in_range;
    // gating by reset discards a response that is in flight when reset arrives
    cpu_rvalid = ~reset & (state == CPU);
    vga_rvalid = ~reset & (state == VGA);
    cpu_rd = (cpu_rvalid & ~oob) ? ram_rd : 32'h0;
    vga_rd = (vga_rvalid & ~oob) ? ram_rd : 32'h0;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= NONE;
      streak <= 4'd0;
      oob <= 1'b0;
      oob_err <= 1'b0;
    end else begin
      state <= state_n;
      streak <= streak_n;
      oob <= ~in_range;
      if ((cpu_win | vga_win) & ~in_range) oob_err <= 1'b1;
    end
  end
endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter in front of the single-port data RAM (`dmem`, 2048 × 32 bit, 8 KB). It multiplexes CPU load/store traffic and read-only VGA framebuffer fetches onto the one RAM port. The CPU has priority; a starvation counter guarantees the VGA fetcher a slot. It also tracks which requester owns the read data returned by the synchronous-read RAM one cycle later.

## Interface
Parameters:
- `STARVE_MAX`, default 4: maximum consecutive CPU grants while `vga_req` is pending, range 1..15.
- `ADDR_LIMIT`, default 32'h0000_2000: first out-of-range byte address.

Ports:
- `clk` in 1: system clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `cpu_req` in 1: CPU access request this cycle.
- `cpu_we` in 1: CPU request is a store.
- `cpu_a` in 32: CPU byte address, word-aligned.
- `cpu_wd` in 32: CPU store data.
- `cpu_stall` out 1: CPU request not granted this cycle; the CPU holds its request.
- `cpu_rvalid` out 1: CPU load data valid.
- `cpu_rd` out 32: CPU load data.
- `vga_req` in 1: VGA fetch request (read only).
- `vga_a` in 32: VGA byte address, word-aligned.
- `vga_gnt` out 1: VGA request accepted this cycle.
- `vga_rvalid` out 1: VGA fetch data valid.
- `vga_rd` out 32: VGA fetch data.
- `ram_we` out 1: RAM write enable.
- `ram_a` out 32: RAM byte address. `dmem` uses bits [12:2].
- `ram_wd` out 32: RAM write data.
- `ram_rd` in 32: RAM read data, valid one cycle after the address is presented.
- `oob_err` out 1: sticky out-of-range access flag.

## Operation
- One grant per cycle. All grant logic is combinational from the current requests and the registered state.
- **Arbitration rule:**
  - CPU wins if `cpu_req` is high and either `vga_req` is low or `streak < STARVE_MAX`.
  - Otherwise VGA wins if `vga_req` is high.
  - Otherwise there is no grant.
- `cpu_stall = cpu_req & ~cpu_granted`.
- `vga_gnt = vga_granted`.
- **Streak counter (4 bit):**
  - Increments on a CPU grant while `vga_req` is high.
  - Clears on a VGA grant, or in any cycle where `vga_req` is low.
  - Saturates at `STARVE_MAX`.
- **RAM drive:**
  - `ram_a` is the granted address, or 0 when there is no grant.
  - `ram_wd = cpu_wd`.
  - `ram_we = cpu_granted & cpu_we & in_range`.
- **Range check:** `in_range = (addr < ADDR_LIMIT)`, an unsigned 32-bit compare.
  - Out-of-range accesses are granted normally but never touch the RAM: `ram_we` stays 0 and `ram_a` is driven as 0.
  - Out-of-range reads return 32'h0.
  - Out-of-range accesses set `oob_err`, which only `reset` clears.
- **Response owner register** (state machine with states NONE, CPU, VGA, plus a registered `oob` bit):
  - A granted read loads CPU or VGA. Any other cycle (write, no grant) loads NONE.
  - `oob` latches `~in_range` of the granted read.
- **Response outputs:**
  - CPU state: `cpu_rvalid = 1` and `cpu_rd = oob ? 0 : ram_rd`.
  - VGA state: same, on `vga_rvalid` / `vga_rd`.
  - Non-owner `rd` outputs are 32'h0, and `rvalid` is low.
- Stores produce no `rvalid`.

## Timing
- **Reset values:**
  - Owner = NONE, `streak` = 0, `oob_err` = 0.
  - Hence `cpu_rvalid` = `vga_rvalid` = 0 and `cpu_rd` = `vga_rd` = 0.
  - In a reset cycle the combinational outputs are forced to: `vga_gnt` = 0, `cpu_stall` = 0, `ram_we` = 0, `ram_a` = 0.
- **Read latency:**
  - A request granted in cycle N has its address on `ram_a` in cycle N.
  - `rvalid` and `rd` appear in cycle N+1, for exactly one cycle.
  - Back-to-back reads give one response per cycle.
- **Write:** committed at the rising edge ending cycle N. A read of the same address granted in N+1 returns the new data in N+2.
- **Simultaneous requests:** tie-break is by the arbitration rule only. The losing requester holds its request; `cpu_stall` and `vga_gnt` are valid before the end of the same cycle.
- **Starvation bound:** with both requests continuously high, the VGA is granted at least once every `STARVE_MAX`+1 cycles.
- **Reset asserted with a read pending:** the response is discarded (no `rvalid` in the following cycle).
- **`oob_err` timing:** goes high at the edge ending the offending grant cycle.

## Test plan
- **Reset:** assert `reset` with both requests high → all outputs 0 during reset and the next cycle; no `ram_we`.
- **CPU store then load:** store 32'hDEADBEEF to 0x100 in cycle 0; load 0x100 in cycle 1 → `cpu_rvalid` in cycle 2 with `cpu_rd` = 32'hDEADBEEF, `vga_rvalid` = 0.
- **Contention, `STARVE_MAX` = 4:** `cpu_req` and `vga_req` held high for 10 cycles → grant pattern C,C,C,C,V,C,C,C,C,V; `cpu_stall` high in cycles 4 and 9.
- **VGA streaming:** `vga_req` with addresses 0x1000, 0x1004, 0x1008 on consecutive cycles, CPU idle → three `vga_rvalid` pulses in cycles 1–3 with the matching RAM data.
- **Out of range:** CPU store to 0x2000, then CPU load from 0x3FFC →
  - `ram_we` = 0 throughout.
  - `cpu_rvalid` with `cpu_rd` = 0.
  - `oob_err` = 1 and stays set until `reset`.
- **Reset mid-read:** CPU load granted in cycle 5, `reset` high in cycle 6 → no `cpu_rvalid` in cycle 6; owner = NONE afterwards.
